// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the execute-stage operation codes and the FSM state encoding used by
// mdu_hilo_unit and its testbench.
package mdu_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider, one quotient bit per step.
// Ports:
//   clk        rising-edge clock
//   load       capture dividend/divisor, clear partial remainder
//   step       perform one shift-subtract iteration
//   dividend   unsigned dividend magnitude
//   divisor    unsigned divisor magnitude
//   quotient   quotient shift register (valid after WIDTH steps)
//   remainder  partial remainder (valid after WIDTH steps)
//   div_zero   divisor captured at load was zero
// Pure datapath: sequencing and reset live in the parent FSM.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic             dz_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // Shift the next dividend bit into the remainder and try the subtract;
    // the borrow bit decides whether the subtraction is kept.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dsr_q};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            dz_q  <= (divisor == '0);
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                // No borrow-free subtract: trial < divisor, so its top bit is zero.
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: rtl/mdu_hilo_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset (aborts an op in flight)
//   start    request valid, sampled only while busy=0
//   op       operation code (mdu_pkg OP_*)
//   rs_data  operand A: multiplicand / dividend / MTHI,MTLO source
//   rt_data  operand B: multiplier / divisor
//   busy     iterative op in flight, execute stage must stall
//   done     one-cycle pulse after HI/LO were written by mult/div
//   hi, lo   HI/LO registers (MFHI/MFLO sources)
// Mult/div operate on unsigned magnitudes for WIDTH cycles, then a single
// FIX cycle applies the two's-complement sign correction and writes HI/LO.
module mdu_hilo_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int IW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [IW-1:0]      iter_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;

    logic               is_iter_op;
    logic               is_signed_op;
    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     psum;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH-1:0]   quo, rem;
    logic               div_zero;
    logic [WIDTH-1:0]   res_hi, res_lo;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        logic signed [WIDTH-1:0] xs;
        xs = $signed(x);
        // The most negative value maps onto itself, which is the correct
        // unsigned magnitude (2^(WIDTH-1)).
        return (sgn && xs < 0) ? $unsigned(-xs) : x;
    endfunction

    function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_2w(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    always_comb begin
        is_iter_op   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        is_signed_op = (op == OP_MULT) || (op == OP_DIV);
        accept       = (state_q == S_IDLE) && start && is_iter_op;
        last_iter    = (iter_q == IW'(WIDTH - 1));
        rs_mag       = mag(rs_data, is_signed_op);
        rt_mag       = mag(rt_data, is_signed_op);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)    state_d = S_CALC;
            S_CALC: if (last_iter) state_d = S_FIX;
            S_FIX:                 state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Control and architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_FIX);
            if (accept)
                iter_q <= '0;
            else if (state_q == S_CALC)
                iter_q <= iter_q + 1'b1;
            if (state_q == S_IDLE && start && op == OP_MTHI)
                hi_q <= rs_data;
            if (state_q == S_IDLE && start && op == OP_MTLO)
                lo_q <= rs_data;
            if (state_q == S_FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    // Shift-add multiplier: low half starts as the multiplier and is shifted
    // out LSB-first while partial products accumulate into the high half.
    always_comb begin
        psum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mcand_q   <= rs_mag;
            acc_q     <= {{WIDTH{1'b0}}, rt_mag};
            is_div_q  <= (op == OP_DIV) || (op == OP_DIVU);
            neg_res_q <= is_signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_rem_q <= is_signed_op && rs_data[WIDTH-1];
        end else if (state_q == S_CALC && !is_div_q) begin
            acc_q <= {psum, acc_q[WIDTH-1:1]};
        end
    end

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .load      (accept),
        .step      (state_q == S_CALC && is_div_q),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .quotient  (quo),
        .remainder (rem),
        .div_zero  (div_zero)
    );

    // Sign fixup. Divide by zero returns the original dividend in HI, which
    // is recovered from its stored magnitude and sign.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (is_div_q) begin
            if (div_zero) begin
                res_hi = fix_w(mcand_q, neg_rem_q);
                res_lo = '1;
            end else begin
                res_hi = fix_w(rem, neg_rem_q);
                res_lo = fix_w(quo, neg_res_q);
            end
        end else begin
            {res_hi, res_lo} = fix_2w(acc_q, neg_res_q);
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
